// File: rtl/ex_mem_stage_if.sv
// Execute -> memory stage bundle: execute beat in, skid-buffer head out, fetch redirect.
// master: the execute/memory side driving beats and out_ready (and flush).
// slave : ex_mem_stage, accepting beats and presenting head entry + redirect/trap pulses.
interface ex_mem_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            flush;
  // execute beat
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] alu_out;
  logic            alu_zero;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] store_data;
  logic [RA_W-1:0] rd_addr;
  logic            is_branch;
  logic            is_jal;
  logic            is_jalr;
  logic [2:0]      funct3;
  logic            mem_read;
  logic            mem_write;
  logic            reg_write;
  // head entry toward memory stage
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [XLEN-1:0] out_store_data;
  logic [RA_W-1:0] out_rd_addr;
  logic [2:0]      out_funct3;
  logic            out_mem_read;
  logic            out_mem_write;
  logic            out_reg_write;
  // control-flow side channel to fetch
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            trap_valid;

  modport master (
    output flush, in_valid, alu_out, alu_zero, pc, imm, store_data, rd_addr,
           is_branch, is_jal, is_jalr, funct3, mem_read, mem_write, reg_write,
           out_ready,
    input  in_ready, out_valid, out_result, out_store_data, out_rd_addr, out_funct3,
           out_mem_read, out_mem_write, out_reg_write, redirect_valid, redirect_pc,
           trap_valid
  );

  modport slave (
    input  flush, in_valid, alu_out, alu_zero, pc, imm, store_data, rd_addr,
           is_branch, is_jal, is_jalr, funct3, mem_read, mem_write, reg_write,
           out_ready,
    output in_ready, out_valid, out_result, out_store_data, out_rd_addr, out_funct3,
           out_mem_read, out_mem_write, out_reg_write, redirect_valid, redirect_pc,
           trap_valid
  );
endinterface

// File: rtl/ex_mem_stage.sv
// Branch/jump resolution + writeback select feeding a 2-entry skid buffer to the memory stage.
// Latency: accepted beat -> out_valid 1 cycle; taken beat -> redirect_valid/trap_valid 1 cycle later.
// Backpressure: in_ready = entries < 2 (no same-cycle bypass when FULL); beats during redirect are dropped.
//
// Ports: clk, rst (synchronous, active-high) and bus (ex_mem_stage_if.slave) carrying flush,
// the execute beat (in_valid/in_ready + fields), the head entry (out_valid/out_ready + out_*),
// and redirect_valid/redirect_pc/trap_valid toward fetch.
// Option EX_MISALIGN_TRAP_EN: a taken target with [1:0]!=0 raises trap_valid instead of redirect,
// the entry is still enqueued with reg_write cleared. Without it, target[1:0] is forced to 00.
module ex_mem_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input logic          clk,
  input logic          rst,
  ex_mem_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [RA_W-1:0] rd_addr;
    logic [2:0]      funct3;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state;
  ent_t            head;
  ent_t            tail;
  ent_t            new_ent;
  logic            redir_q;
  logic            trap_q;
  logic [XLEN-1:0] redir_pc_q;

  logic            accept;
  logic            pop;
  logic            br_cond;
  logic            taken;
  logic [XLEN-1:0] raw_target;
  logic [XLEN-1:0] redir_target;
  logic            redir_go;
  logic            trap_go;
  logic            kill_wb;

  // Handshake. A beat arriving while a redirect is being signalled is from the wrong path.
  assign bus.in_ready = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign accept = bus.in_valid & bus.in_ready & ~redir_q & ~bus.flush;
  assign pop    = bus.out_valid & bus.out_ready;

  // Branch condition: signed/unsigned less-than comes from the ALU compare bit in alu_out[0].
  always_comb begin
    br_cond = 1'b0;
    case (bus.funct3)
      3'b000:         br_cond = bus.alu_zero;
      3'b001:         br_cond = ~bus.alu_zero;
      3'b100, 3'b110: br_cond = bus.alu_out[0];
      3'b101, 3'b111: br_cond = ~bus.alu_out[0];
      default:        br_cond = 1'b0;
    endcase
  end

  assign taken      = bus.is_jal | bus.is_jalr | (bus.is_branch & br_cond);
  assign raw_target = bus.is_jalr ? (bus.alu_out & ~XLEN'(1)) : (bus.pc + bus.imm);

`ifdef EX_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign     = |raw_target[1:0];
  assign redir_target = raw_target;
  assign redir_go     = accept & taken & ~misalign;
  assign trap_go      = accept & taken & misalign;
  assign kill_wb      = bus.is_branch | (taken & misalign);
`else
  assign redir_target = raw_target & ~XLEN'(3);
  assign redir_go     = accept & taken;
  assign trap_go      = 1'b0;
  assign kill_wb      = bus.is_branch;
`endif

  // Link value for jumps, ALU result (arith value or memory address) otherwise.
  always_comb begin
    new_ent            = '0;
    new_ent.result     = (bus.is_jal | bus.is_jalr) ? (bus.pc + XLEN'(4)) : bus.alu_out;
    new_ent.store_data = bus.store_data;
    new_ent.rd_addr    = bus.rd_addr;
    new_ent.funct3     = bus.funct3;
    new_ent.mem_read   = bus.mem_read;
    new_ent.mem_write  = bus.mem_write;
    new_ent.reg_write  = bus.reg_write & ~kill_wb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      head       <= '0;
      tail       <= '0;
      redir_q    <= 1'b0;
      trap_q     <= 1'b0;
      redir_pc_q <= '0;
    end else if (bus.flush) begin
      // Data registers keep stale contents; out_valid is what qualifies them.
      state   <= EMPTY;
      redir_q <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      redir_q <= redir_go;
      trap_q  <= trap_go;
      if (redir_go | trap_go) redir_pc_q <= redir_target;

      case (state)
        EMPTY: begin
          if (accept) begin
            head  <= new_ent;
            state <= ONE;
          end
        end
        ONE: begin
          if (accept & pop) begin
            head <= new_ent;
          end else if (accept) begin
            tail  <= new_ent;
            state <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            head  <= tail;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.out_result     = head.result;
  assign bus.out_store_data = head.store_data;
  assign bus.out_rd_addr    = head.rd_addr;
  assign bus.out_funct3     = head.funct3;
  assign bus.out_mem_read   = head.mem_read;
  assign bus.out_mem_write  = head.mem_write;
  assign bus.out_reg_write  = head.reg_write;
  assign bus.redirect_valid = redir_q;
  assign bus.redirect_pc    = redir_pc_q;
  assign bus.trap_valid     = trap_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: scoreboard queues for head entries, redirects and traps,
// filled when beats are driven and drained by a negedge monitor.
// Scenario tasks add inline checks on handshake timing and reset/flush state.
module tb_ex_mem_stage;

  typedef struct packed {
    logic [31:0] alu_out;
    logic        zero;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        br;
    logic        jal;
    logic        jalr;
    logic        mr;
    logic        mw;
    logic        rw;
  } beat_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        mr;
    logic        mw;
    logic        rw;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  out_t        sbq[$];
  logic [31:0] redq[$];
  logic [31:0] trapq[$];

  ex_mem_stage_if bus ();

  ex_mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic model_taken(input beat_t b);
    logic c;
    c = 1'b0;
    if (b.jal || b.jalr) return 1'b1;
    if (!b.br) return 1'b0;
    case (b.f3)
      3'b000: c = b.zero;
      3'b001: c = !b.zero;
      3'b100: c = b.alu_out[0];
      3'b110: c = b.alu_out[0];
      3'b101: c = !b.alu_out[0];
      3'b111: c = !b.alu_out[0];
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] model_tgt(input beat_t b);
    if (b.jalr) return {b.alu_out[31:1], 1'b0};
    return b.pc + b.imm;
  endfunction

  function automatic out_t model_out(input beat_t b);
    out_t        o;
    logic [31:0] t;
    t        = model_tgt(b);
    o.result = (b.jal || b.jalr) ? b.pc + 32'd4 : b.alu_out;
    o.sd     = b.sd;
    o.rd     = b.rd;
    o.f3     = b.f3;
    o.mr     = b.mr;
    o.mw     = b.mw;
    o.rw     = b.rw && !b.br;
`ifdef EX_MISALIGN_TRAP_EN
    if (model_taken(b) && t[1:0] != 2'b00) o.rw = 1'b0;
`endif
    return o;
  endfunction

  task automatic push_exp(input beat_t b);
    logic [31:0] t;
    sbq.push_back(model_out(b));
    if (model_taken(b)) begin
      t = model_tgt(b);
`ifdef EX_MISALIGN_TRAP_EN
      if (t[1:0] != 2'b00) trapq.push_back(t);
      else redq.push_back(t);
`else
      redq.push_back({t[31:2], 2'b00});
`endif
    end
  endtask

  function automatic beat_t mk_alu(input logic [31:0] v, input logic [4:0] rd);
    beat_t b;
    b = '0;
    b.alu_out = v;
    b.pc = 32'h1000;
    b.sd = v ^ 32'hA5A5_0000;
    b.rd = rd;
    b.f3 = 3'b010;
    b.rw = 1'b1;
    return b;
  endfunction

  function automatic beat_t mk_br(input logic [2:0] f3, input logic [31:0] v, input logic z,
                                  input logic [31:0] pc, input logic [31:0] imm);
    beat_t b;
    b = '0;
    b.br = 1'b1;
    b.f3 = f3;
    b.alu_out = v;
    b.zero = z;
    b.pc = pc;
    b.imm = imm;
    b.rd = 5'd5;
    b.rw = 1'b1;
    return b;
  endfunction

  task automatic drive(input beat_t b);
    bus.in_valid   = 1'b1;
    bus.alu_out    = b.alu_out;
    bus.alu_zero   = b.zero;
    bus.pc         = b.pc;
    bus.imm        = b.imm;
    bus.store_data = b.sd;
    bus.rd_addr    = b.rd;
    bus.funct3     = b.f3;
    bus.is_branch  = b.br;
    bus.is_jal     = b.jal;
    bus.is_jalr    = b.jalr;
    bus.mem_read   = b.mr;
    bus.mem_write  = b.mw;
    bus.reg_write  = b.rw;
  endtask

  // Offer one beat, wait (bounded) for in_ready, then leave one idle cycle.
  task automatic offer(input beat_t b);
    int n;
    drive(b);
    push_exp(b);
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL offer_in_ready: got %b want 1 after %0d cycles", bus.in_ready, n);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  out_t        act;
  out_t        expv;
  logic [31:0] exp_pc;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        act = {bus.out_result, bus.out_store_data, bus.out_rd_addr, bus.out_funct3,
               bus.out_mem_read, bus.out_mem_write, bus.out_reg_write};
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL head_unexpected: got %h, none expected", act);
        end else begin
          expv = sbq.pop_front();
          if (act !== expv) begin
            fails++;
            $display("FAIL head_entry: got %h want %h", act, expv);
          end
        end
      end
      if (bus.redirect_valid) begin
        tests++;
        if (redq.size() == 0) begin
          fails++;
          $display("FAIL redirect_unexpected: pc %h", bus.redirect_pc);
        end else begin
          exp_pc = redq.pop_front();
          if (bus.redirect_pc !== exp_pc) begin
            fails++;
            $display("FAIL redirect_pc: got %h want %h", bus.redirect_pc, exp_pc);
          end
        end
      end
      if (bus.trap_valid) begin
        tests++;
        if (trapq.size() == 0) begin
          fails++;
          $display("FAIL trap_unexpected: pc %h", bus.redirect_pc);
        end else begin
          exp_pc = trapq.pop_front();
          if (bus.redirect_pc !== exp_pc) begin
            fails++;
            $display("FAIL trap_pc: got %h want %h", bus.redirect_pc, exp_pc);
          end
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    tests++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    tests++;
    if ({bus.redirect_valid, bus.trap_valid} !== 2'b00) begin
      fails++; $display("FAIL reset_pulses: got %b%b want 00", bus.redirect_valid, bus.trap_valid);
    end
    tests++;
    if ({bus.out_result, bus.out_reg_write, bus.redirect_pc} !== 65'd0) begin
      fails++; $display("FAIL reset_data: result %h rw %b rpc %h want 0", bus.out_result, bus.out_reg_write, bus.redirect_pc);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_add();
    bus.out_ready = 1'b1;
    drive(mk_alu(32'h15, 5'd3));
    push_exp(mk_alu(32'h15, 5'd3));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.out_result, bus.out_reg_write} !== {1'b1, 32'h15, 1'b1}) begin
      fails++; $display("FAIL add_latency: valid %b result %h rw %b want 1 00000015 1", bus.out_valid, bus.out_result, bus.out_reg_write);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int n;
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(mk_alu(32'(i), 5'(i)));
      push_exp(mk_alu(32'(i), 5'(i)));
      if (i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests++;
      if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
      tests++;
      if (bus.out_result !== 32'h1) begin fails++; $display("FAIL head_hold: got %h want 1", bus.out_result); end
      @(posedge clk);
    end
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL full_pop_no_bypass: got %b want 0", bus.in_ready); end
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL drain_in_ready: got %b want 1", bus.in_ready); end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    beat_t b;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = mk_alu(32'h100 + 32'(i), 5'(10 + i));
      if (i == 2) begin
        b.mw = 1'b1;
        b.rw = 1'b0;
        b.sd = 32'hCAFE_F00D;
      end
      drive(b);
      push_exp(b);
      @(negedge clk);
      tests++;
      if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_branch_redirect();
    beat_t b;
    bus.out_ready = 1'b1;
    b = mk_br(3'b001, 32'h0, 1'b0, 32'h100, 32'h20);
    drive(b);
    push_exp(b);
    @(posedge clk);
    #1 drive(mk_alu(32'hDEAD, 5'd9));
    @(negedge clk);
    tests++;
    if (bus.redirect_valid !== 1'b1) begin fails++; $display("FAIL bne_redirect: got %b want 1", bus.redirect_valid); end
    tests++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL wrongpath_in_ready: got %b want 1", bus.in_ready); end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.redirect_valid !== 1'b0) begin fails++; $display("FAIL redirect_one_cycle: got %b want 0", bus.redirect_valid); end
    tests++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL wrongpath_dropped: out_valid %b want 0", bus.out_valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_jumps();
    beat_t b;
    bus.out_ready = 1'b1;
    b = '0;
    b.jalr = 1'b1; b.alu_out = 32'h2003; b.pc = 32'h40; b.rd = 5'd1; b.rw = 1'b1;
    offer(b);
    b = '0;
    b.jal = 1'b1; b.pc = 32'hFFFF_FFF0; b.imm = 32'h20; b.rd = 5'd1; b.rw = 1'b1;
    offer(b);
  endtask

  task automatic test_branches();
    beat_t tbl[6];
    tbl[0] = mk_br(3'b111, 32'h1, 1'b0, 32'h180, 32'h40);
    tbl[1] = mk_br(3'b000, 32'h0, 1'b1, 32'h200, 32'hFFFF_FFF0);
    tbl[2] = mk_br(3'b100, 32'h1, 1'b0, 32'h300, 32'h8);
    tbl[3] = mk_br(3'b010, 32'h1, 1'b1, 32'h400, 32'h10);
    tbl[4] = mk_br(3'b001, 32'h0, 1'b1, 32'h500, 32'h10);
    tbl[5] = mk_br(3'b000, 32'h0, 1'b1, 32'h100, 32'h2);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) offer(tbl[i]);
  endtask

  task automatic test_flush();
    beat_t j;
    j = '0;
    j.jal = 1'b1; j.pc = 32'h800; j.imm = 32'h40; j.rd = 5'd2; j.rw = 1'b1;
    bus.out_ready = 1'b0;
    drive(mk_alu(32'hAA, 5'd4));
    @(posedge clk);
    #1 drive(mk_alu(32'hBB, 5'd4));
    @(posedge clk);
    #1 drive(j);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.redirect_valid} !== 2'b00) begin
      fails++; $display("FAIL flush_full: out_valid %b redirect %b want 0 0", bus.out_valid, bus.redirect_valid);
    end
    @(posedge clk);
    #1 drive(j);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.redirect_valid} !== 2'b00) begin
      fails++; $display("FAIL flush_drop_beat: out_valid %b redirect %b want 0 0", bus.out_valid, bus.redirect_valid);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    drive(mk_alu(32'h77, 5'd6));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.out_result, bus.redirect_pc} !== 65'd0) begin
      fails++; $display("FAIL reset_mid: valid %b result %h rpc %h want 0", bus.out_valid, bus.out_result, bus.redirect_pc);
    end
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.alu_out = '0; bus.alu_zero = 1'b0; bus.pc = '0; bus.imm = '0; bus.store_data = '0;
    bus.rd_addr = '0; bus.funct3 = '0; bus.is_branch = 1'b0; bus.is_jal = 1'b0; bus.is_jalr = 1'b0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.reg_write = 1'b0;

    test_reset();
    test_add();
    test_backpressure();
    test_back_to_back();
    test_branch_redirect();
    test_jumps();
    test_branches();
    test_flush();

    n = 0;
    while ((sbq.size() != 0 || redq.size() != 0 || trapq.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    tests++;
    if (sbq.size() != 0) begin fails++; $display("FAIL sb_drain: %0d entries left want 0", sbq.size()); end
    tests++;
    if (redq.size() != 0) begin fails++; $display("FAIL redirect_drain: %0d left want 0", redq.size()); end
    tests++;
    if (trapq.size() != 0) begin fails++; $display("FAIL trap_drain: %0d left want 0", trapq.size()); end

    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
